// File: rtl/address_decoder_pkg.sv
// Shared types and memory-map constants for the 68000 address decoder.
package address_decoder_pkg;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_SRAM = 2'd1,
    REG_PROM = 2'd2
  } region_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    WAIT   = 3'd2,
    ACK    = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam logic [23:0] SRAM_BASE  = 24'h000000;
  localparam logic [23:0] SRAM_LIMIT = 24'h0FFFFF;
  localparam logic [23:0] PROM_BASE  = 24'hF00000;
  localparam logic [23:0] PROM_LIMIT = 24'hFFFFFF;
  localparam logic [23:0] VEC_LIMIT  = 24'h000007;

  // Inclusive window test; the modular subtraction avoids constant-true compares at the map edges.
  function automatic logic in_range(logic [23:0] addr, logic [23:0] base, logic [23:0] limit);
    return (addr - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/address_decoder_if.sv
// CPU-side bus bundle: strobes and address in, chip selects and handshake out.
interface address_decoder_if;
  logic        AS_IN;
  logic        UDS_IN;
  logic        LDS_IN;
  logic        RW_IN;
  logic [23:0] ADDR_IN;
  logic        SRAMCS0;
  logic        SRAMCS1;
  logic        PROMCS0;
  logic        PROMCS1;
  logic        OE;
  logic        DTACK;
  logic        BERR;
  logic        OVERLAY;

  modport master (
    output AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN,
    input  SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, DTACK, BERR, OVERLAY
  );

  modport slave (
    input  AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN,
    output SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, DTACK, BERR, OVERLAY
  );
endinterface

// File: rtl/address_decoder_bus_timeout.sv
// AS-qualified saturating 8-bit bus-cycle counter; expired_o flags the edge on which it reaches TIMEOUT.
module bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic as_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (as_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Looks at the next count so the FSM can raise BERR on the same edge the count hits TIMEOUT.
  assign expired_o = !clr_i && as_i && (cnt_d >= 8'(TIMEOUT));

endmodule

// File: rtl/address_decoder.sv
// 68000 bus decoder: region decode, byte-lane selects, wait-state DTACK and BERR timeout.
// Boot overlay (PROM mirrored at 0 for the vector fetch) is built only with ADDRESS_DECODER_BOOT_OVERLAY_EN.
module address_decoder
  import address_decoder_pkg::*;
#(
  parameter int SRAM_WAIT   = 0,
  parameter int PROM_WAIT   = 2,
  parameter int TIMEOUT     = 64,
  parameter int BOOT_CYCLES = 4
) (
  input logic              CPUCLK_IN,
  input logic              RESET_IN,
  address_decoder_if.slave bus
);

  state_e     state_q, state_d;
  region_e    region_q, region_d, dec_region_s, lane_rgn_s;
  logic [7:0] wait_q, wait_d;
  logic       sram_cs0_q, sram_cs0_d, sram_cs1_q, sram_cs1_d;
  logic       prom_cs0_q, prom_cs0_d, prom_cs1_q, prom_cs1_d;
  logic       oe_q, oe_d, dtack_q, dtack_d, berr_q, berr_d;
  logic       expired_s, overlay_s;

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (CPUCLK_IN),
    .rst_i     (RESET_IN),
    .clr_i     (state_q == IDLE),
    .as_i      (bus.AS_IN),
    .expired_o (expired_s)
  );

  always_comb begin
    dec_region_s = REG_NONE;
    if (in_range(bus.ADDR_IN, PROM_BASE, PROM_LIMIT)) begin
      dec_region_s = bus.RW_IN ? REG_PROM : REG_NONE;
`ifdef ADDRESS_DECODER_BOOT_OVERLAY_EN
    end else if (in_range(bus.ADDR_IN, SRAM_BASE, SRAM_LIMIT)) begin
      dec_region_s = (overlay_s && bus.RW_IN) ? REG_PROM : REG_SRAM;
`else
    end else if (in_range(bus.ADDR_IN, SRAM_BASE, VEC_LIMIT)) begin
      dec_region_s = bus.RW_IN ? REG_PROM : REG_NONE;
    end else if (in_range(bus.ADDR_IN, SRAM_BASE, SRAM_LIMIT)) begin
      dec_region_s = REG_SRAM;
`endif
    end else begin
      dec_region_s = REG_NONE;
    end
  end

  // Lanes follow the live strobes every cycle, so RMW strobe changes land one edge later.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    wait_d     = wait_q;
    lane_rgn_s = REG_NONE;
    oe_d       = 1'b0;
    dtack_d    = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = bus.AS_IN ? DECODE : IDLE;
      end
      DECODE: begin
        if (!bus.AS_IN) begin
          state_d = IDLE;
        end else if (expired_s) begin
          state_d = FAULT;
          berr_d  = 1'b1;
        end else begin
          region_d = dec_region_s;
          if (dec_region_s == REG_NONE) begin
            state_d = FAULT;
          end else begin
            lane_rgn_s = dec_region_s;
            oe_d       = bus.RW_IN;
            wait_d     = (dec_region_s == REG_SRAM) ? 8'(SRAM_WAIT) : 8'(PROM_WAIT);
            if (wait_d == 8'd0) begin
              state_d = ACK;
              dtack_d = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!bus.AS_IN) begin
          state_d = IDLE;
        end else if (expired_s) begin
          state_d = FAULT;
          berr_d  = 1'b1;
        end else begin
          lane_rgn_s = region_q;
          oe_d       = oe_q;
          wait_d     = wait_q - 8'd1;
          if (wait_d == 8'd0) begin
            state_d = ACK;
            dtack_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      ACK: begin
        if (!bus.AS_IN) begin
          state_d = IDLE;
        end else begin
          lane_rgn_s = region_q;
          oe_d       = oe_q;
          dtack_d    = 1'b1;
        end
      end
      FAULT: begin
        if (!bus.AS_IN) begin
          state_d = IDLE;
        end else begin
          berr_d = berr_q | expired_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sram_cs0_d = (lane_rgn_s == REG_SRAM) && bus.UDS_IN;
    sram_cs1_d = (lane_rgn_s == REG_SRAM) && bus.LDS_IN;
    prom_cs0_d = (lane_rgn_s == REG_PROM) && bus.UDS_IN;
    prom_cs1_d = (lane_rgn_s == REG_PROM) && bus.LDS_IN;
  end

  // State and registered bus outputs.
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state_q    <= IDLE;
      region_q   <= REG_NONE;
      wait_q     <= 8'd0;
      sram_cs0_q <= 1'b0;
      sram_cs1_q <= 1'b0;
      prom_cs0_q <= 1'b0;
      prom_cs1_q <= 1'b0;
      oe_q       <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      wait_q     <= wait_d;
      sram_cs0_q <= sram_cs0_d;
      sram_cs1_q <= sram_cs1_d;
      prom_cs0_q <= prom_cs0_d;
      prom_cs1_q <= prom_cs1_d;
      oe_q       <= oe_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
    end
  end

`ifdef ADDRESS_DECODER_BOOT_OVERLAY_EN
  localparam int OVL_W = $clog2(BOOT_CYCLES + 1);

  logic [OVL_W-1:0] ovl_cnt_q, ovl_cnt_d;
  logic             overlay_q, overlay_d;

  // Only completed (ACK -> IDLE) cycles advance the overlay; aborts and faults never reach ACK release.
  always_comb begin
    ovl_cnt_d = ovl_cnt_q;
    overlay_d = overlay_q;
    if (overlay_q && (state_q == ACK) && !bus.AS_IN) begin
      ovl_cnt_d = ovl_cnt_q + OVL_W'(1);
      overlay_d = (ovl_cnt_d != OVL_W'(BOOT_CYCLES));
    end else begin
      ovl_cnt_d = ovl_cnt_q;
    end
  end

  // Overlay counter; reset re-arms the overlay.
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      ovl_cnt_q <= '0;
      overlay_q <= 1'b1;
    end else begin
      ovl_cnt_q <= ovl_cnt_d;
      overlay_q <= overlay_d;
    end
  end

  assign overlay_s = overlay_q;
`else
  assign overlay_s = 1'b0;
`endif

  assign bus.SRAMCS0 = sram_cs0_q;
  assign bus.SRAMCS1 = sram_cs1_q;
  assign bus.PROMCS0 = prom_cs0_q;
  assign bus.PROMCS1 = prom_cs1_q;
  assign bus.OE      = oe_q;
  assign bus.DTACK   = dtack_q;
  assign bus.BERR    = berr_q;
  assign bus.OVERLAY = overlay_s;

endmodule

// File: tb/tb_address_decoder.sv
// Directed self-checking bench for address_decoder; expectations follow ADDRESS_DECODER_BOOT_OVERLAY_EN.
module tb_address_decoder;

`ifdef ADDRESS_DECODER_BOOT_OVERLAY_EN
  localparam logic OVL_EN = 1'b1;
`else
  localparam logic OVL_EN = 1'b0;
`endif

  // Output vector order: {SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, DTACK, BERR}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] P_RD   = 7'b0011100;
  localparam logic [6:0] P_RDA  = 7'b0011110;
  localparam logic [6:0] S_RDA  = 7'b1100110;
  localparam logic [6:0] S_WRL  = 7'b0100010;
  localparam logic [6:0] B_ERR  = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  address_decoder_if bus ();

  address_decoder #(
    .SRAM_WAIT(0), .PROM_WAIT(2), .TIMEOUT(64), .BOOT_CYCLES(4)
  ) dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [23:0] a, input logic rw, input logic u, input logic l);
    bus.ADDR_IN = a;
    bus.RW_IN   = rw;
    bus.UDS_IN  = u;
    bus.LDS_IN  = l;
    bus.AS_IN   = 1'b1;
  endtask

  task automatic release_bus();
    bus.AS_IN  = 1'b0;
    bus.UDS_IN = 1'b0;
    bus.LDS_IN = 1'b0;
  endtask

  function automatic logic [6:0] outs();
    return {bus.SRAMCS0, bus.SRAMCS1, bus.PROMCS0, bus.PROMCS1, bus.OE, bus.DTACK, bus.BERR};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    release_bus();
    bus.ADDR_IN = 24'h000000;
    bus.RW_IN   = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL reset_outs: got %b want %b", outs(), O_IDLE);
    else passes++;
    checks++;
    if (bus.OVERLAY !== OVL_EN) $display("FAIL reset_overlay: got %b want %b", bus.OVERLAY, OVL_EN);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL idle_outs: got %b want %b", outs(), O_IDLE);
    else passes++;
  endtask

  task automatic test_boot_reads();
    logic [6:0] seq [4];
    seq = '{O_IDLE, P_RD, P_RD, P_RDA};
    for (int i = 0; i < 4; i++) begin
      start(24'(2 * i), 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (outs() !== seq[c]) $display("FAIL boot_read%0d_cyc%0d: got %b want %b", i, c, outs(), seq[c]);
        else passes++;
      end
      release_bus();
      tick();
      checks++;
      if (outs() !== O_IDLE) $display("FAIL boot_release%0d: got %b want %b", i, outs(), O_IDLE);
      else passes++;
      checks++;
      if (bus.OVERLAY !== ((i < 3) ? OVL_EN : 1'b0))
        $display("FAIL boot_overlay%0d: got %b want %b", i, bus.OVERLAY, (i < 3) ? OVL_EN : 1'b0);
      else passes++;
      tick();
    end
  endtask

  task automatic test_post_overlay_read();
    logic [6:0] seq [4];
    // Without the overlay the vector area stays PROM; with it, address 0 is SRAM again.
    seq = OVL_EN ? '{O_IDLE, S_RDA, S_RDA, S_RDA} : '{O_IDLE, P_RD, P_RD, P_RDA};
    start(24'h000000, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (outs() !== seq[c]) $display("FAIL post_ovl_read_cyc%0d: got %b want %b", c, outs(), seq[c]);
      else passes++;
    end
    release_bus();
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL post_ovl_release: got %b want %b", outs(), O_IDLE);
    else passes++;
    tick();
  endtask

  task automatic test_byte_write();
    logic [6:0] seq [3];
    seq = '{O_IDLE, S_WRL, S_WRL};
    start(24'h000101, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (outs() !== seq[c]) $display("FAIL byte_write_cyc%0d: got %b want %b", c, outs(), seq[c]);
      else passes++;
    end
    release_bus();
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL byte_write_release: got %b want %b", outs(), O_IDLE);
    else passes++;
    tick();
  endtask

  task automatic test_rmw_lanes();
    start(24'h000200, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (outs() !== 7'b1000110) $display("FAIL rmw_upper: got %b want %b", outs(), 7'b1000110);
    else passes++;
    bus.UDS_IN = 1'b0;
    bus.LDS_IN = 1'b1;
    tick();
    checks++;
    if (outs() !== 7'b0100110) $display("FAIL rmw_lower: got %b want %b", outs(), 7'b0100110);
    else passes++;
    release_bus();
    tick();
    tick();
  endtask

  task automatic test_unmapped();
    logic [23:0] addrs [2];
    logic        rws   [2];
    int          bad;
    addrs = '{24'h400000, 24'hF00010};
    rws   = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      start(addrs[i], rws[i], 1'b1, 1'b1);
      tick();
      bad = 0;
      for (int k = 1; k < 64; k++) begin
        tick();
        if (outs() !== O_IDLE) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL unmapped%0d_early: got %0d busy cycles want 0", i, bad);
      else passes++;
      tick();
      checks++;
      if (outs() !== B_ERR) $display("FAIL unmapped%0d_berr: got %b want %b", i, outs(), B_ERR);
      else passes++;
      tick();
      checks++;
      if (outs() !== B_ERR) $display("FAIL unmapped%0d_hold: got %b want %b", i, outs(), B_ERR);
      else passes++;
      release_bus();
      tick();
      checks++;
      if (outs() !== O_IDLE) $display("FAIL unmapped%0d_release: got %b want %b", i, outs(), O_IDLE);
      else passes++;
      tick();
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [6:0] seq [4];
    seq = '{O_IDLE, P_RD, P_RD, P_RDA};
    start(24'hF00000, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (outs() !== P_RD) $display("FAIL midrst_prom_cs: got %b want %b", outs(), P_RD);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL midrst_outs: got %b want %b", outs(), O_IDLE);
    else passes++;
    checks++;
    if (bus.OVERLAY !== OVL_EN) $display("FAIL midrst_overlay: got %b want %b", bus.OVERLAY, OVL_EN);
    else passes++;
    rst = 1'b0;
    release_bus();
    tick();
    start(24'h000000, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (outs() !== seq[c]) $display("FAIL midrst_read_cyc%0d: got %b want %b", c, outs(), seq[c]);
      else passes++;
    end
    release_bus();
    tick();
    tick();
  endtask

  task automatic test_abort_wait();
    start(24'h000002, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (outs() !== P_RD) $display("FAIL abort_cs: got %b want %b", outs(), P_RD);
    else passes++;
    release_bus();
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL abort_drop: got %b want %b", outs(), O_IDLE);
    else passes++;
    tick();
    tick();
    checks++;
    if (outs() !== O_IDLE) $display("FAIL abort_no_dtack: got %b want %b", outs(), O_IDLE);
    else passes++;
    // One completed read since reset; the abort must not count, so three more end the overlay.
    for (int k = 0; k < 3; k++) begin
      start(24'(2 * k), 1'b1, 1'b1, 1'b1);
      tick();
      tick();
      tick();
      tick();
      checks++;
      if (outs() !== P_RDA) $display("FAIL abort_follow%0d_ack: got %b want %b", k, outs(), P_RDA);
      else passes++;
      release_bus();
      tick();
      checks++;
      if (bus.OVERLAY !== ((k < 2) ? OVL_EN : 1'b0))
        $display("FAIL abort_follow%0d_overlay: got %b want %b", k, bus.OVERLAY, (k < 2) ? OVL_EN : 1'b0);
      else passes++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    release_bus();
    bus.ADDR_IN = 24'h000000;
    bus.RW_IN   = 1'b1;
    test_reset();
    test_boot_reads();
    test_post_overlay_read();
    test_byte_write();
    test_rmw_lanes();
    test_unmapped();
    test_reset_mid_cycle();
    test_abort_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
